mem_access_unit: RTL and testbench

- Initiator side of the word-addressed data memory port: accepts load/store requests from the core and drives the memory's address, write-data and write-enable.
- The memory returns read data combinationally.
- The memory stores whole 32-bit words only, so byte and halfword stores run as read-modify-write.
- Loads are extended to 32 bits here. Misaligned or invalid requests are rejected here without touching memory.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_lane_align.sv | 59 +++++
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RISC-V funct3 width codes used on the request interface.
//   - FSM state encoding for mem_access_unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering between the 32-bit memory word and the core.
//   mem_word   in  : word read from memory
//   funct3     in  : width code of the access
//   lane       in  : byte offset within the word (addr[1:0])
//   wdata      in  : store data from the core (low bits used for B/H)
//   load_data  out : selected lane, sign/zero extended to 32 bits
//   merge_word out : mem_word with the store lane replaced by wdata
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = 8'd0;
    half_sel   = 16'd0;
    load_data  = mem_word;
    merge_word = mem_word;

    case (lane)
      2'd0:    byte_sel = mem_word[7:0];
      2'd1:    byte_sel = mem_word[15:8];
      2'd2:    byte_sel = mem_word[23:16];
      default: byte_sel = mem_word[31:24];
    endcase
    // Halfword lane is picked by addr[1] alone; addr[0] is known zero here
    // because odd halfword accesses are rejected before reaching memory.
    half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = mem_word;
    endcase

    if (funct3 == F3_B) begin
      case (lane)
        2'd0:    merge_word[7:0]   = wdata[7:0];
        2'd1:    merge_word[15:8]  = wdata[7:0];
        2'd2:    merge_word[23:16] = wdata[7:0];
        default: merge_word[31:24] = wdata[7:0];
      endcase
    end else if (funct3 == F3_H) begin
      if (lane[1]) merge_word[31:16] = wdata[15:0];
      else         merge_word[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed data memory.
// Accepts one load/store request at a time, checks it, and drives the
// memory port. Byte/halfword stores are done as read-modify-write.
//
// Handshake: req is looked at only while busy=0 (IDLE); a request seen
// there is taken on that rising edge and its operands are latched, so the
// core may change them afterwards. Requests while busy are dropped, not
// queued. Completion is a single-cycle done pulse; misaligned/fault are
// valid with done and hold until the next request is taken.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   req, store, funct3    request strobe, direction, width code
//   addr, wdata           byte address, store data
//   busy, done            not-idle flag, completion pulse
//   rdata                 extended load result (changes on good loads only)
//   misaligned, fault     error status
//   mem_address           word-aligned address to memory
//   mem_data_in, mem_we   write word and write enable to memory
//   mem_data_out          combinational read word from memory
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_we
);

  lsu_state_e  state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misaligned_q, misaligned_d;
  logic        fault_q, fault_d;

  logic        req_fault;
  logic        req_misaligned;
  logic        bad_funct3;
  logic        out_of_range;
  logic [31:0] load_data;
  logic [31:0] merge_word;

  lsu_lane_align u_lane_align (
    .mem_word   (mem_data_out),
    .funct3     (funct3_q),
    .lane       (addr_q[1:0]),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  // Request checks on the live inputs, used only at acceptance.
  always_comb begin
    bad_funct3 = 1'b1;
    if (store) begin
      bad_funct3 = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    end else begin
      bad_funct3 = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                     funct3 == F3_BU || funct3 == F3_HU);
    end
    out_of_range   = (addr >> ADDR_BITS) != 32'd0;
    req_fault      = bad_funct3 || out_of_range;
    req_misaligned = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                     (funct3 == F3_W && addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    rdata_d      = rdata_q;
    misaligned_d = misaligned_q;
    fault_d      = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          store_d      = store;
          funct3_d     = funct3;
          addr_d       = addr;
          wdata_d      = wdata;
          // Fault outranks misalignment so only one flag is ever raised.
          fault_d      = req_fault;
          misaligned_d = !req_fault && req_misaligned;
          if (req_fault || req_misaligned) state_d = ST_RESP;
          else if (!store)                 state_d = ST_LOAD;
          else if (funct3 == F3_W)         state_d = ST_WRITE;
          else                             state_d = ST_RMW_READ;
        end
      end
      ST_LOAD: begin
        rdata_d = load_data;
        state_d = ST_RESP;
      end
      ST_RMW_READ: begin
        merge_d = merge_word;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      merge_q      <= 32'd0;
      rdata_q      <= 32'd0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      fault_q      <= fault_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_RESP);
  assign mem_we      = (state_q == ST_WRITE);
  assign rdata       = rdata_q;
  assign misaligned  = misaligned_q;
  assign fault       = fault_q;
  assign mem_address = {addr_q[31:2], 2'b00};
  // Both sources are cleared by reset, so this reads zero after reset.
  assign mem_data_in = (store_q && funct3_q == F3_W) ? wdata_q : merge_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        resetn;
  logic        req;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        fault;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_we;

  int checks;
  int failures;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_BITS(14)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req          (req),
    .store        (store),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .rdata        (rdata),
    .misaligned   (misaligned),
    .fault        (fault),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_we       (mem_we)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_idx;
  logic [31:0] pl_data;

  assign mem_data_out = mem[mem_address[13:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_we) mem[mem_address[13:2]] <= mem_data_in;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
    pl_en = 1'b1;
    pl_idx = byte_addr[13:2];
    pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the
  // first IDLE cycle after done, so the next call is back-to-back.
  task automatic run_req(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int dcyc, output int wcnt, output int wcyc,
                         output logic [31:0] waddr, output logic [31:0] wdat,
                         output logic [31:0] r_at_done, output logic mis_at_done,
                         output logic flt_at_done, output logic [31:0] maddr_at_done);
    int cyc;
    req = 1'b1; store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    // scramble operands to prove they were latched
    store = 1'($urandom_range(0, 1));
    funct3 = 3'($urandom_range(0, 7));
    addr = $urandom;
    wdata = $urandom;
    cyc = 1; dcyc = -1; wcnt = 0; wcyc = -1; waddr = 32'd0; wdat = 32'd0;
    r_at_done = 32'd0; mis_at_done = 1'b0; flt_at_done = 1'b0; maddr_at_done = 32'd0;
    while (cyc < 20) begin
      if (mem_we) begin
        wcnt++; wcyc = cyc; waddr = mem_address; wdat = mem_data_in;
      end
      if (done) begin
        dcyc = cyc;
        r_at_done = rdata; mis_at_done = misaligned; flt_at_done = fault;
        maddr_at_done = mem_address;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (dcyc < 0) begin
      chk("done_timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    chk("done_pulse_width", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          done_cyc;
    int          we_cyc;     // -1: no write expected
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
    logic [31:0] mem_word;   // word at a&~3 after the access (stores)
  } vec_t;

  vec_t vecs[$];

  initial begin
    int dcyc, wcnt, wcyc;
    logic [31:0] waddr, wdat, r_d, maddr_d;
    logic mis_d, flt_d;
    logic [31:0] exp_r;
    int n_done, n_we, done_at, we_at;

    checks = 0; failures = 0;
    resetn = 1'b0; req = 1'b0; store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0;
    pl_en = 1'b0; pl_idx = 12'd0; pl_data = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_data_in", mem_data_in, 32'd0);

    preload(32'h100, 32'h8899AABB);
    preload(32'h300, 32'h11223344);
    resetn = 1'b1;
    @(negedge clk);

    //               name     st  f3      addr          wdata        dc we  rdata         mis flt mem_word
    vecs.push_back('{"lb_101",  0, 3'b000, 32'h101,  32'h0,        2, -1, 32'hFFFFFFAA, 0, 0, 32'h0});
    vecs.push_back('{"lbu_101", 0, 3'b100, 32'h101,  32'h0,        2, -1, 32'h000000AA, 0, 0, 32'h0});
    vecs.push_back('{"lhu_102", 0, 3'b101, 32'h102,  32'h0,        2, -1, 32'h00008899, 0, 0, 32'h0});
    vecs.push_back('{"lh_100",  0, 3'b001, 32'h100,  32'h0,        2, -1, 32'hFFFFAABB, 0, 0, 32'h0});
    vecs.push_back('{"sw_200",  1, 3'b010, 32'h200,  32'hDEADBEEF, 2,  1, 32'hFFFFAABB, 0, 0, 32'hDEADBEEF});
    vecs.push_back('{"lw_200",  0, 3'b010, 32'h200,  32'h0,        2, -1, 32'hDEADBEEF, 0, 0, 32'h0});
    vecs.push_back('{"sb_302",  1, 3'b000, 32'h302,  32'h000000EE, 3,  2, 32'hDEADBEEF, 0, 0, 32'h11EE3344});
    vecs.push_back('{"sh_302",  1, 3'b001, 32'h302,  32'h0000CAFE, 3,  2, 32'hDEADBEEF, 0, 0, 32'hCAFE3344});
    vecs.push_back('{"lw_203",  0, 3'b010, 32'h203,  32'h0,        1, -1, 32'hDEADBEEF, 1, 0, 32'h0});
    vecs.push_back('{"s_f3_100",1, 3'b100, 32'h300,  32'h12345678, 1, -1, 32'hDEADBEEF, 0, 1, 32'hCAFE3344});
    vecs.push_back('{"lw_4000", 0, 3'b010, 32'h4000, 32'h0,        1, -1, 32'hDEADBEEF, 0, 1, 32'h0});
    vecs.push_back('{"lb_303",  0, 3'b000, 32'h303,  32'h0,        2, -1, 32'hFFFFFFCA, 0, 0, 32'h0});
    vecs.push_back('{"s_f3_011",1, 3'b011, 32'h300,  32'h0,        1, -1, 32'hFFFFFFCA, 0, 1, 32'hCAFE3344});
    vecs.push_back('{"lh_301",  0, 3'b001, 32'h301,  32'h0,        1, -1, 32'hFFFFFFCA, 1, 0, 32'h0});
    vecs.push_back('{"lw_4001", 0, 3'b010, 32'h4001, 32'h0,        1, -1, 32'hFFFFFFCA, 0, 1, 32'h0});
    vecs.push_back('{"lhu_300", 0, 3'b101, 32'h300,  32'h0,        2, -1, 32'h00003344, 0, 0, 32'h0});
    vecs.push_back('{"sb_100",  1, 3'b000, 32'h100,  32'h12345677, 3,  2, 32'h00003344, 0, 0, 32'h8899AA77});
    vecs.push_back('{"lb_100",  0, 3'b000, 32'h100,  32'h0,        2, -1, 32'h00000077, 0, 0, 32'h0});

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].rdata);
      run_req(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd,
              dcyc, wcnt, wcyc, waddr, wdat, r_d, mis_d, flt_d, maddr_d);
      exp_r = exp_q.pop_front();
      chk({vecs[i].name, "_done_cyc"}, 32'(dcyc), 32'(vecs[i].done_cyc));
      chk({vecs[i].name, "_rdata"}, r_d, exp_r);
      chk({vecs[i].name, "_mis"}, {31'd0, mis_d}, {31'd0, vecs[i].mis});
      chk({vecs[i].name, "_fault"}, {31'd0, flt_d}, {31'd0, vecs[i].flt});
      chk({vecs[i].name, "_mem_address"}, maddr_d, vecs[i].a & 32'hFFFFFFFC);
      if (vecs[i].we_cyc < 0) begin
        chk({vecs[i].name, "_we_count"}, 32'(wcnt), 32'd0);
      end else begin
        chk({vecs[i].name, "_we_count"}, 32'(wcnt), 32'd1);
        chk({vecs[i].name, "_we_cyc"}, 32'(wcyc), 32'(vecs[i].we_cyc));
        chk({vecs[i].name, "_we_addr"}, waddr, vecs[i].a & 32'hFFFFFFFC);
        chk({vecs[i].name, "_we_data"}, wdat, vecs[i].mem_word);
      end
      if (vecs[i].st) begin
        chk({vecs[i].name, "_mem_word"}, mem[vecs[i].a[13:2]], vecs[i].mem_word);
      end
    end

    // ---- requests while busy are dropped ----
    req = 1'b1; store = 1'b1; funct3 = 3'b000; addr = 32'h300; wdata = 32'h00000055;
    n_done = 0; n_we = 0; done_at = -1; we_at = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done) begin n_done++; done_at = c; end
      if (mem_we) begin n_we++; we_at = c; end
      req = (c <= 2);
      store = 1'b0; funct3 = 3'b010; addr = 32'h100; wdata = 32'h0;
    end
    chk("busy_req_done_count", 32'(n_done), 32'd1);
    chk("busy_req_done_cyc", 32'(done_at), 32'd3);
    chk("busy_req_we_count", 32'(n_we), 32'd1);
    chk("busy_req_we_cyc", 32'(we_at), 32'd2);
    chk("busy_req_mem_word", mem[12'h0C0], 32'hCAFE3355);
    chk("busy_req_rdata", rdata, 32'h00000077);

    // ---- reset during RMW_READ ----
    req = 1'b1; store = 1'b1; funct3 = 3'b000; addr = 32'h300; wdata = 32'h00000099;
    @(negedge clk);
    req = 1'b0;
    chk("rmw_rst_busy_before", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    n_we = 0;
    @(negedge clk);
    if (mem_we) n_we++;
    chk("rmw_rst_busy", {31'd0, busy}, 32'd0);
    chk("rmw_rst_done", {31'd0, done}, 32'd0);
    chk("rmw_rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rmw_rst_fault", {31'd0, fault}, 32'd0);
    chk("rmw_rst_rdata", rdata, 32'd0);
    chk("rmw_rst_mem_address", mem_address, 32'd0);
    chk("rmw_rst_mem_data_in", mem_data_in, 32'd0);
    repeat (2) begin
      @(negedge clk);
      if (mem_we) n_we++;
    end
    resetn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (mem_we) n_we++;
    end
    chk("rmw_rst_we_count", 32'(n_we), 32'd0);
    chk("rmw_rst_mem_word", mem[12'h0C0], 32'hCAFE3355);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
